pool_controller: RTL
====================

// Module: pool_controller
// PURPOSE
//  Sequences 2x2/stride-2 max pooling of one N x N signed feature map held in a sync-read buffer.
//  Fetches the 4 pixels of each window in raster order (window row-major) and registers them.
//  Reduces each window with one shared pool_window instance.
//  Streams pooled pixels with a valid/ready handshake to the next CNN layer's buffer.
//  Sits between the conv output buffer and the next layer; started by the top-level layer sequencer.
// PARAMETERS
//  N     28                  input map side; odd N -> last row/column ignored (floor)
//  DW    16                  pixel width, signed two's complement
//  AW    $clog2(N*N)         input buffer address width
//  OAW   $clog2((N/2)*(N/2)) output index width (min 1)
// PORTS
//  clk        in   1    single clock, rising edge
//  rst_n      in   1    synchronous active-low reset
//  start      in   1    begin pooling one map; sampled only in IDLE
//  busy       out  1    high from cycle after accepted start until done
//  done       out  1    1-cycle pulse after last output accepted
//  rd_en      out  1    buffer read strobe
//  rd_addr    out  AW   buffer address, pixel (r,c) = r*N+c
//  rd_data    in   DW   buffer data, valid exactly 1 cycle after rd_en
//  out_valid  out  1    pooled pixel available
//  out_ready  in   1    consumer accepts when out_valid & out_ready
//  out_data   out  DW   signed max of the window
//  out_addr   out  OAW  window index wr*(N/2)+wc
// BEHAVIOUR
//  Reset (rst_n=0 at posedge):
//   - all outputs 0; FSM -> IDLE; window regs and counters 0.
//   - Mid-operation reset abandons the map; no done pulse.
//  FSM: IDLE -> READ0..READ3 -> CAPT -> WRITE -> (READ0 | FIN) -> IDLE.
//   IDLE:    start=1 -> READ0; busy=1 from next cycle.
//   READk:   rd_en=1; rd_addr in order (2wr*N+2wc), +1, (2wr+1)*N+2wc, +1.
//            Data for READk-1 is captured into win[k-1].
//   CAPT:    rd_en=0; capture win[3].
//            Register pool_window(win) into out_data and out_addr; set out_valid.
//   WRITE:   hold out_valid/out_data/out_addr stable until out_ready.
//            On handshake: clear out_valid, advance wc (wrap to 0 at N/2, increment wr).
//            Next state READ0, or FIN if it was the last window.
//   FIN:     done=1 for 1 cycle; busy=0; -> IDLE.
//  Timing:
//   - start sampled cycle 0 -> rd_en cycles 1-4 -> out_valid first high cycle 6.
//   - With out_ready held 1: 6 cycles per window.
//   - Total cycles for N=4: 4*6 + 1 (FIN) = 25.
//  Boundaries:
//   - start while busy: ignored, no effect.
//   - start in FIN cycle: ignored.
//   - out_ready high outside WRITE: ignored.
//   - out_ready low: FSM stalls in WRITE indefinitely; no reads issued.
//  Arithmetic: signed compare, no saturation or rounding; out_data is one of the 4 inputs bit-exact.
//   -32768 is a valid minimum.
// STRUCTURE
//  pool_pkg:
//   - typedef logic signed [DW-1:0] pixel_t; typedef pixel_t window_t [0:3];
//   - typedef enum {IDLE,READ0,READ1,READ2,READ3,CAPT,WRITE,FIN} pool_state_e.
//  Sub-module: pool_window (combinational 4-input signed max), one instance fed by win regs.
//  Controller is one FSM plus wr/wc counters and an address generator.
// TESTING (N=4 unless noted)
//  1. Map (r,c)=4r+c, values 0..15, out_ready=1:
//     - outputs (addr,data) = (0,5),(1,7),(2,13),(3,15); done at cycle 25.
//  2. All negative, pixel=-(4r+c)-1:
//     - outputs -1,-3,-9,-11.
//     - window {-32768,-32768,-32768,-32767} -> -32767.
//  3. Backpressure, out_ready low 10 cycles at window 1:
//     - out_valid/out_data=7/out_addr=1 held stable; rd_en stays 0; resumes after ready.
//  4. start pulsed again at cycles 3 and 12:
//     - ignored; exactly 4 outputs and one done pulse.
//  5. rst_n=0 during READ2 of window 2:
//     - next cycle all outputs 0, IDLE.
//     - fresh start yields full correct sequence from addr 0.
//  6. N=5 (odd), map 0..24:
//     - 4 outputs 6,8,16,18; row/col 4 never addressed (no rd_addr >= 20 or with c=4).

Source files
------------

// File: rtl/pool_controller_pkg.sv
// Shared types for the 2x2/stride-2 max-pooling controller.
//   pixel_t      : signed feature-map pixel (DW bits, two's complement)
//   window_t     : the four pixels of one pooling window, raster order
//   pool_state_e : controller FSM states
//   max2         : signed maximum of two pixels
package pool_controller_pkg;

    localparam int DW = 16;

    typedef logic signed [DW-1:0] pixel_t;
    typedef pixel_t window_t [0:3];

    typedef enum logic [2:0] {
        IDLE,
        READ0,
        READ1,
        READ2,
        READ3,
        CAPT,
        WRITE,
        FIN
    } pool_state_e;

    function automatic pixel_t max2(input pixel_t a, input pixel_t b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pool_controller_if.sv
// Bus between the pooling controller, its layer sequencer, the input map
// buffer and the next layer's buffer.
//   start/busy/done                  : sequencer control
//   rd_en/rd_addr/rd_data            : sync-read input buffer (data 1 cycle after rd_en)
//   out_valid/out_ready/out_data/out_addr : pooled pixel stream
// master = pooling controller, slave = its environment.
interface pool_controller_if #(
    parameter int AW  = 10,
    parameter int OAW = 8
);
    import pool_controller_pkg::*;

    logic           start;
    logic           busy;
    logic           done;
    logic           rd_en;
    logic [AW-1:0]  rd_addr;
    pixel_t         rd_data;
    logic           out_valid;
    logic           out_ready;
    pixel_t         out_data;
    logic [OAW-1:0] out_addr;

    modport master (
        input  start, rd_data, out_ready,
        output busy, done, rd_en, rd_addr, out_valid, out_data, out_addr
    );

    modport slave (
        output start, rd_data, out_ready,
        input  busy, done, rd_en, rd_addr, out_valid, out_data, out_addr
    );

endinterface

// File: rtl/pool_controller_window.sv
// pool_window: combinational signed maximum of one 2x2 window.
//   i_win : four window pixels
//   o_max : the largest of them, bit-exact copy of one input
module pool_window
    import pool_controller_pkg::*;
(
    input  window_t i_win,
    output pixel_t  o_max
);

    pixel_t w_top;
    pixel_t w_bot;

    assign w_top = max2(i_win[0], i_win[1]);
    assign w_bot = max2(i_win[2], i_win[3]);
    assign o_max = max2(w_top, w_bot);

endmodule

// File: rtl/pool_controller.sv
// pool_controller: sequences 2x2/stride-2 max pooling of one N x N signed map.
// Each window takes READ0..READ3 (four buffer reads), CAPT (last pixel in,
// result registered) and WRITE (hold until the consumer accepts).
//   clk    : clock, rising edge
//   rst_n  : synchronous active-low reset
//   io_bus : controller side of pool_controller_if (control, buffer read, output stream)
// Odd N drops the last row and column.
module pool_controller
    import pool_controller_pkg::*;
#(
    parameter int N   = 28,
    parameter int AW  = $clog2(N*N),
    parameter int OAW = (((N/2)*(N/2)) > 1) ? $clog2((N/2)*(N/2)) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    pool_controller_if.master io_bus
);

    localparam int NH  = N / 2;
    localparam int WCW = (NH > 1) ? $clog2(NH) : 1;

    pool_state_e    r_state;
    pool_state_e    w_next;
    logic [WCW-1:0] r_wr;
    logic [WCW-1:0] r_wc;
    window_t        r_win;
    window_t        w_win;
    pixel_t         w_max;
    logic           r_out_valid;
    pixel_t         r_out_data;
    logic [OAW-1:0] r_out_addr;
    logic [OAW-1:0] w_oaddr;
    logic [AW-1:0]  w_base;
    logic [AW-1:0]  w_off;
    logic           w_rd_en;
    logic           w_wc_wrap;
    logic           w_last;

    assign w_wc_wrap = (r_wc == WCW'(NH - 1));
    assign w_last    = w_wc_wrap && (r_wr == WCW'(NH - 1));

    // Top-left pixel of the current window: (2wr)*N + 2wc.
    assign w_base  = AW'(r_wr) * AW'(2 * N) + AW'(r_wc) * AW'(2);
    assign w_oaddr = OAW'(r_wr) * OAW'(NH) + OAW'(r_wc);

    // In CAPT the fourth pixel is still on rd_data, so the reducer sees it
    // directly; this lets the result register in the same cycle.
    always_comb begin
        w_win    = r_win;
        w_win[3] = (r_state == CAPT) ? io_bus.rd_data : r_win[3];
    end

    pool_window u_pool_window (
        .i_win (w_win),
        .o_max (w_max)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = r_state;
        w_rd_en = 1'b0;
        w_off   = '0;
        case (r_state)
            IDLE:  if (io_bus.start) w_next = READ0;
            READ0: begin w_rd_en = 1'b1;                       w_next = READ1; end
            READ1: begin w_rd_en = 1'b1; w_off = AW'(1);       w_next = READ2; end
            READ2: begin w_rd_en = 1'b1; w_off = AW'(N);       w_next = READ3; end
            READ3: begin w_rd_en = 1'b1; w_off = AW'(N + 1);   w_next = CAPT;  end
            CAPT:  w_next = WRITE;
            WRITE: if (io_bus.out_ready) w_next = w_last ? FIN : READ0;
            FIN:   w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    assign io_bus.rd_en     = w_rd_en;
    assign io_bus.rd_addr   = w_rd_en ? (w_base + w_off) : '0;
    assign io_bus.busy      = (r_state != IDLE) && (r_state != FIN);
    assign io_bus.done      = (r_state == FIN);
    assign io_bus.out_valid = r_out_valid;
    assign io_bus.out_data  = r_out_data;
    assign io_bus.out_addr  = r_out_addr;

    // Each READk cycle receives the data requested in READk-1.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr        <= '0;
            r_wc        <= '0;
            r_win       <= '{default: '0};
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_addr  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (io_bus.start) begin
                        r_wr <= '0;
                        r_wc <= '0;
                    end
                end
                READ1: r_win[0] <= io_bus.rd_data;
                READ2: r_win[1] <= io_bus.rd_data;
                READ3: r_win[2] <= io_bus.rd_data;
                CAPT: begin
                    r_win[3]    <= io_bus.rd_data;
                    r_out_data  <= w_max;
                    r_out_addr  <= w_oaddr;
                    r_out_valid <= 1'b1;
                end
                WRITE: begin
                    if (io_bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        if (w_wc_wrap) begin
                            r_wc <= '0;
                            // Counters return to 0 after the last window.
                            r_wr <= w_last ? '0 : r_wr + WCW'(1);
                        end else begin
                            r_wc <= r_wc + WCW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
